// File: rtl/ahb_resp_mux_n_pkg.sv
// Shared encodings and helpers for the N-slave AHB response multiplexer.
// The ahb_resp_mux_n top reads the AHB_MUX_TIMEOUT_EN macro; nothing in this package depends on it.
package ahb_mux_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam int MAX_SLV = 16;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } def_state_e;

   // Callers zero-extend their select vector to MAX_SLV bits.
   function automatic logic is_onehot(input logic [MAX_SLV-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/ahb_resp_mux_n_if.sv
// Bus bundle between the slave bank, the decoder and the master side of the response mux.
// The slave modport is the mux's view; the master modport is the view of whatever drives it.
interface ahb_resp_mux_n_if #(
   parameter int NUM_SLV = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_SLV-1:0]        hsel;
   logic [1:0]                htrans;
   logic [NUM_SLV-1:0]        hready_s;
   logic [NUM_SLV-1:0]        hresp_s;
   logic [NUM_SLV*DATA_W-1:0] hrdata_s;
   logic [DATA_W-1:0]         hrdata;
   logic                      hready;
   logic                      hresp;

   // Handshake: a transfer's address phase is accepted on any rising edge
   // where hready=1; its data phase then lasts until the next edge with
   // hready=1, and hresp/hrdata belong to that data phase.
   modport slave (
      input  hsel, htrans, hready_s, hresp_s, hrdata_s,
      output hrdata, hready, hresp
   );

   modport master (
      output hsel, htrans, hready_s, hresp_s, hrdata_s,
      input  hrdata, hready, hresp
   );
endinterface

// File: rtl/ahb_resp_mux_n_default_slave.sv
// Built-in default slave: two-cycle AHB ERROR response for unmapped,
// multiply-decoded or timed-out transfers; OKAY with no wait states otherwise.
module ahb_default_slave
   import ahb_mux_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cap,
   input  logic       trans,
   input  logic       decode_err,
   input  logic       force_err,
   output logic       hready_def,
   output logic       hresp_def,
   output def_state_e state
);

   def_state_e state_q;
   def_state_e state_d;
   logic       bad_xfer;

   assign bad_xfer = cap && trans && decode_err;
   assign state    = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hready_def = 1'b1;
      hresp_def  = HRESP_OKAY;
      case (state_q)
         DS_IDLE: begin
            if (force_err || bad_xfer) begin
               state_d = DS_ERR1;
            end
         end
         DS_ERR1: begin
            hready_def = 1'b0;
            hresp_def  = HRESP_ERROR;
            state_d    = DS_ERR2;
         end
         DS_ERR2: begin
            // hready is high here, so the next address phase is taken on this edge.
            hresp_def = HRESP_ERROR;
            state_d   = bad_xfer ? DS_ERR1 : DS_IDLE;
         end
         default: begin
            state_d = DS_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/ahb_resp_mux_n.sv
// N-slave AHB read-data/response mux with registered data-phase select and built-in default slave.
// Optional wait-state timeout (timeout_irq/timeout_clr ports) is built when AHB_MUX_TIMEOUT_EN is defined.
module ahb_resp_mux_n
   import ahb_mux_pkg::*;
#(
   parameter int NUM_SLV        = 4,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   ahb_resp_mux_n_if.slave       bus,
   output logic [NUM_SLV-1:0]    sel_dp,
   output def_state_e            dbg_state
`ifdef AHB_MUX_TIMEOUT_EN
   ,
   input  logic                  timeout_clr,
   output logic                  timeout_irq
`endif
);

   logic              sel_onehot;
   logic              decode_err;
   logic              to_active;
   logic              force_err;
   logic              trans_in;
   logic              hready_def;
   logic              hresp_def;
   logic              use_def;
   logic [DATA_W-1:0] mux_rdata;
   logic              mux_ready;
   logic              mux_resp;

   assign sel_onehot = is_onehot(MAX_SLV'(sel_dp));
   assign decode_err = !is_onehot(MAX_SLV'(bus.hsel));

`ifdef AHB_MUX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic             trans_dp;
   logic [CNT_W-1:0] stall_cnt;
   logic             to_active_q;
   logic             stall;
   logic             hit;

   // Stalls during a timeout-owned data phase are not counted again.
   assign stall     = sel_onehot && trans_dp && !to_active_q && !mux_ready;
   assign hit       = stall && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign to_active = to_active_q;
   assign force_err = hit;
   assign trans_in  = bus.htrans[1] && !to_active_q;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         sel_dp      <= '0;
         trans_dp    <= 1'b0;
         stall_cnt   <= '0;
         to_active_q <= 1'b0;
         timeout_irq <= 1'b0;
      end else begin
         if (bus.hready) begin
            sel_dp   <= to_active_q ? '0 : bus.hsel;
            trans_dp <= to_active_q ? 1'b0 : bus.htrans[1];
         end
         if (!stall || hit) begin
            stall_cnt <= '0;
         end else begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         // The default slave's ERR2 cycle is the last cycle the timeout owns the bus.
         if (hit) begin
            to_active_q <= 1'b1;
         end else if (dbg_state == DS_ERR2) begin
            to_active_q <= 1'b0;
         end
         if (hit) begin
            timeout_irq <= 1'b1;
         end else if (timeout_clr) begin
            timeout_irq <= 1'b0;
         end
      end
   end
`else
   assign to_active = 1'b0;
   assign force_err = 1'b0;
   assign trans_in  = bus.htrans[1];

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         sel_dp <= '0;
      end else if (bus.hready) begin
         sel_dp <= bus.hsel;
      end
   end
`endif

   ahb_default_slave u_default_slave (
      .clk        (hclk),
      .rst_n      (hresetn),
      .cap        (bus.hready),
      .trans      (trans_in),
      .decode_err (decode_err),
      .force_err  (force_err),
      .hready_def (hready_def),
      .hresp_def  (hresp_def),
      .state      (dbg_state)
   );

   always_comb begin
      mux_rdata = '0;
      mux_ready = 1'b0;
      mux_resp  = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         mux_rdata = mux_rdata | (bus.hrdata_s[i*DATA_W +: DATA_W] & {DATA_W{sel_dp[i]}});
         mux_ready = mux_ready | (bus.hready_s[i] & sel_dp[i]);
         mux_resp  = mux_resp  | (bus.hresp_s[i]  & sel_dp[i]);
      end
   end

   assign use_def = !sel_onehot || to_active;

   always_comb begin
      bus.hrdata = mux_rdata;
      bus.hready = mux_ready;
      bus.hresp  = mux_resp;
      if (use_def) begin
         bus.hrdata = '0;
         bus.hready = hready_def;
         bus.hresp  = hresp_def;
      end
   end

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Directed bench for ahb_resp_mux_n (NUM_SLV=4, DATA_W=32, TIMEOUT_CYCLES=16).
// Inputs change 2ns after a rising edge; outputs are sampled 1ns later.
module tb_ahb_resp_mux_n;
   import ahb_mux_pkg::*;

   localparam int NS = 4;
   localparam int DW = 32;

   logic          hclk;
   logic          hresetn;
   logic [NS-1:0] sel_dp;
   def_state_e    dbg_state;
   int            checks;
   int            errors;
   int            bad;
`ifdef AHB_MUX_TIMEOUT_EN
   logic          timeout_clr;
   logic          timeout_irq;
`endif

   ahb_resp_mux_n_if #(.NUM_SLV(NS), .DATA_W(DW)) bus ();

   ahb_resp_mux_n #(.NUM_SLV(NS), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .bus       (bus),
      .sel_dp    (sel_dp),
      .dbg_state (dbg_state)
`ifdef AHB_MUX_TIMEOUT_EN
      ,
      .timeout_clr (timeout_clr),
      .timeout_irq (timeout_irq)
`endif
   );

   // clock / reset
   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic tick;
      @(posedge hclk);
      #2;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic rdy, input logic rsp);
      chk({tag, "_hready"}, 32'(bus.hready), 32'(rdy));
      chk({tag, "_hresp"},  32'(bus.hresp),  32'(rsp));
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      hresetn         = 1'b0;
      bus.hsel        = '0;
      bus.htrans      = HTRANS_IDLE;
      bus.hready_s    = 4'b1111;
      bus.hresp_s     = 4'b0000;
      bus.hrdata_s    = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
`ifdef AHB_MUX_TIMEOUT_EN
      timeout_clr     = 1'b0;
`endif
      #2;
      chk_bus("rst", 1'b1, 1'b0);
      chk("rst_hrdata", bus.hrdata, 32'h0);
      chk("rst_sel_dp", 32'(sel_dp), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'(DS_IDLE));
      tick;
      tick;
      hresetn = 1'b1;

      // 1: routing to slave 2
      bus.hsel = 4'b0100; bus.htrans = HTRANS_NONSEQ;
      tick;
      bus.hsel = 4'b0000; bus.htrans = HTRANS_IDLE;
      settle;
      chk("route_sel_dp", 32'(sel_dp), 32'h4);
      chk("route_hrdata", bus.hrdata, 32'hCAFE_0002);
      chk_bus("route", 1'b1, 1'b0);
      tick;

      // 2: slave 1 inserts three wait states while the decoder moves to slave 3
      bus.hsel = 4'b0010; bus.htrans = HTRANS_NONSEQ;
      tick;
      bus.hsel = 4'b1000; bus.hready_s = 4'b1101;
      settle;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (sel_dp !== 4'b0010 || bus.hready !== 1'b0) bad++;
         tick;
         settle;
      end
      chk("wait_hold_bad", 32'(bad), 32'h0);
      bus.hready_s = 4'b1111;
      settle;
      chk("wait_release_sel_dp", 32'(sel_dp), 32'h2);
      chk("wait_release_hready", 32'(bus.hready), 32'h1);
      tick;
      bus.hsel = 4'b0000; bus.htrans = HTRANS_IDLE;
      settle;
      chk("wait_next_sel_dp", 32'(sel_dp), 32'h8);
      chk("wait_next_hrdata", bus.hrdata, 32'hCAFE_0003);

      // 3: single unmapped NONSEQ, then two back-to-back
      bus.htrans = HTRANS_NONSEQ;
      tick;
      bus.htrans = HTRANS_IDLE;
      settle;
      chk_bus("unm_err1", 1'b0, 1'b1);
      chk("unm_err1_state", 32'(dbg_state), 32'(DS_ERR1));
      tick;
      chk_bus("unm_err2", 1'b1, 1'b1);
      chk("unm_err2_hrdata", bus.hrdata, 32'h0);
      tick;
      chk_bus("unm_okay", 1'b1, 1'b0);
      bus.htrans = HTRANS_NONSEQ;
      tick;
      chk_bus("b2b_err1a", 1'b0, 1'b1);
      tick;
      chk_bus("b2b_err2a", 1'b1, 1'b1);
      tick;
      chk_bus("b2b_err1b", 1'b0, 1'b1);
      tick;
      chk_bus("b2b_err2b", 1'b1, 1'b1);
      bus.htrans = HTRANS_IDLE;
      tick;
      chk_bus("b2b_okay", 1'b1, 1'b0);

      // 4: multiply-decoded NONSEQ, then IDLE to no slave
      bus.hsel = 4'b0011; bus.htrans = HTRANS_NONSEQ;
      tick;
      bus.hsel = 4'b0000; bus.htrans = HTRANS_IDLE;
      settle;
      chk_bus("multi_err1", 1'b0, 1'b1);
      chk("multi_sel_dp", 32'(sel_dp), 32'h3);
      tick;
      chk_bus("multi_err2", 1'b1, 1'b1);
      tick;
      chk_bus("idle_unm", 1'b1, 1'b0);
      chk("idle_unm_state", 32'(dbg_state), 32'(DS_IDLE));
      chk("idle_unm_sel_dp", 32'(sel_dp), 32'h0);

      // 5: slave 3 two-cycle ERROR mirrored, then reset during ERR1
      bus.hsel = 4'b1000; bus.htrans = HTRANS_NONSEQ;
      tick;
      bus.hsel = 4'b0000; bus.htrans = HTRANS_IDLE;
      bus.hresp_s = 4'b1000; bus.hready_s = 4'b0111;
      settle;
      chk_bus("slverr1", 1'b0, 1'b1);
      tick;
      bus.hready_s = 4'b1111;
      settle;
      chk_bus("slverr2", 1'b1, 1'b1);
      tick;
      bus.hresp_s = 4'b0000;
      settle;
      chk_bus("slverr_done", 1'b1, 1'b0);
      bus.htrans = HTRANS_NONSEQ;
      tick;
      bus.htrans = HTRANS_IDLE;
      settle;
      chk_bus("rstmid_err1", 1'b0, 1'b1);
      hresetn = 1'b0;
      settle;
      chk_bus("rstmid", 1'b1, 1'b0);
      chk("rstmid_state", 32'(dbg_state), 32'(DS_IDLE));
      #1;
      hresetn = 1'b1;
      tick;
      chk_bus("rstmid_after", 1'b1, 1'b0);
      chk("rstmid_after_state", 32'(dbg_state), 32'(DS_IDLE));

      // 6: slave 0 stalls indefinitely
      bus.hsel = 4'b0001; bus.htrans = HTRANS_NONSEQ;
      tick;
      bus.hsel = 4'b0000; bus.htrans = HTRANS_IDLE;
      bus.hready_s = 4'b1110;
      settle;
      bad = 0;
`ifdef AHB_MUX_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         if (bus.hready !== 1'b0 || bus.hresp !== 1'b0 || timeout_irq !== 1'b0) bad++;
         tick;
         settle;
      end
      chk("to_stall_bad", 32'(bad), 32'h0);
      chk_bus("to_err1", 1'b0, 1'b1);
      chk("to_irq_set", 32'(timeout_irq), 32'h1);
      tick;
      chk_bus("to_err2", 1'b1, 1'b1);
      tick;
      chk_bus("to_okay", 1'b1, 1'b0);
      chk("to_sel_dp", 32'(sel_dp), 32'h0);
      chk("to_state", 32'(dbg_state), 32'(DS_IDLE));
      bus.hready_s = 4'b1111;
      tick;
      tick;
      chk("to_irq_sticky", 32'(timeout_irq), 32'h1);
      timeout_clr = 1'b1;
      tick;
      timeout_clr = 1'b0;
      settle;
      chk("to_irq_clr", 32'(timeout_irq), 32'h0);
`else
      for (int i = 0; i < 100; i++) begin
         if (bus.hready !== 1'b0 || bus.hresp !== 1'b0 || sel_dp !== 4'b0001) bad++;
         tick;
         settle;
      end
      chk("stall100_bad", 32'(bad), 32'h0);
      chk("stall100_state", 32'(dbg_state), 32'(DS_IDLE));
      bus.hready_s = 4'b1111;
      settle;
      chk_bus("stall_release", 1'b1, 1'b0);
      chk("stall_release_hrdata", bus.hrdata, 32'hCAFE_0000);
      tick;
      chk("stall_next_sel_dp", 32'(sel_dp), 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
